bsg_manycore_link_sif_responder_array: RTL and testbench
========================================================

// Module: bsg_manycore_link_sif_responder_array
// PURPOSE
//  Terminates num_links_p unused manycore edge links (W/E/io ports of the mesh wrapper) with an active responder.
//  - Every request packet is accepted and answered: loads return error data, everything else returns a credit.
//  - Stray traffic therefore never hangs a tile's credit counter.
//  - Stray requests and responses are counted per link; the first offence raises a sticky error.
//  - Parametrised successor of the passive per-link tie-off.
// PARAMETERS
//  addr_width_p    "inv"         packet EPA width, in words
//  data_width_p    "inv"         packet payload width
//  x_cord_width_p  "inv"         X coordinate width
//  y_cord_width_p  "inv"         Y coordinate width
//  num_links_p     1             number of terminated links
//  fifo_els_p      2             response buffer depth per link; legal range 1..8
//  count_width_p   16            width of the saturating event counters
//  error_data_p    32'hDEADBEEF  data returned for a stray load (truncated or zero-extended to data_width_p)
// PORTS
//  clk_i               in   1                        clock
//  reset_n_i           in   1                        asynchronous, active-low reset
//  link_sif_i          in   [num_links_p][link_sif_w] links from the mesh
//  link_sif_o          out  [num_links_p][link_sif_w] links to the mesh
//  clear_i             in   1                        synchronous clear of counters, capture state and error
//  stray_req_cnt_o     out  [num_links_p][count_width_p] requests received per link
//  stray_rsp_cnt_o     out  [num_links_p][count_width_p] responses received per link
//  err_o               out  [num_links_p]            sticky: link saw any traffic
//  first_src_x_o       out  [num_links_p][x_cord_width_p] source X of first stray request
//  first_src_y_o       out  [num_links_p][y_cord_width_p] source Y of first stray request
//  first_addr_o        out  [num_links_p][addr_width_p]   address of first stray request
// BEHAVIOUR
//  - Reset: all FIFOs are flushed. All fwd/rev valid outputs = 0. All counters, err_o and first_* = 0.
//    fwd ready_and_rev = 0 while reset_n_i is low.
//  - Request side
//    - fwd ready_and_rev = !rsp_fifo_full. It does not depend on same-cycle dequeue, so there is no combinational path to rev ready.
//    - Request accepted when fwd.v & ready.
//    - Response pushed in the same cycle; it appears on rev.v the next cycle (latency 1).
//  - Response build
//    - e_remote_load → return type e_return_int_wb, data = error_data_p.
//    - All other ops (store, amo, ...) → e_return_credit, data = 0.
//    - reg_id echoes the request; dst x/y = request src x/y.
//  - Response drain: rev.v = !fifo_empty. Pop when rev.v & rev.ready_and_rev. FIFO order is preserved.
//  - Incoming rev traffic: ready_and_rev is held at 1, the packet is discarded, and stray_rsp_cnt is incremented.
//  - Counters
//    - Increment by 1 per accepted packet and saturate at all-ones; no wrap-around.
//    - clear_i zeroes them. If clear_i and an event coincide, the result is 1.
//  - err_o[i]: set on the first accepted request or response on link i. Cleared only by clear_i or reset; set wins over clear in the same cycle.
//  - A FIFO-full stall on one link never affects other links.
//  - Reset mid-operation drops queued responses. This is legal only when the whole mesh is also in reset.
// CONFIGURATION
//  BSG_MANYCORE_RESPONDER_CAPTURE_EN
//  - Defined: on the first accepted request after reset or clear, link i latches src x/y and addr into first_* (and holds them).
//    If clear_i and a request coincide, the new request is captured.
//  - Undefined: first_* are tied to 0 and no capture flops are built. All other behaviour is identical.
// STRUCTURE
//  - bsg_manycore_pkg: packet_s / return_packet_s macros; e_remote_load and e_return_* encodings; new localparam responder_max_fifo_els_gp = 8.
//  - Sub-module bsg_manycore_link_sif_responder: one link, instantiated num_links_p times via generate.
//    Contains a bsg_fifo_1r1w_small of return packets, two saturating counters, the sticky flag and the optional capture regs.
// TESTING
//  1. Load, link 0, src(2,3), addr 0x40 → next cycle rev.v=1, type int_wb, data 0xDEADBEEF, dst(2,3); stray_req_cnt[0]=1; err_o[0]=1.
//  2. Store on link 1 → credit response, data 0. Links 0 and 2 show no counter change.
//  3. rev.ready held 0; fifo_els_p=2; 3 back-to-back loads → 2 accepted, fwd ready=0. Release ready → 2 responses in order, then the third is accepted.
//  4. count_width_p=4; 20 requests → stray_req_cnt=15, held. clear_i pulsed together with one request → 1.
//  5. With the macro defined: requests from (1,0) then (3,2) → first_src=(1,0). Without the macro: first_* = 0.
//  6. Assert reset_n_i low with 2 responses queued → rev.v drops asynchronously. After release: counters 0, err_o 0, fwd ready=1.

Source files
------------

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore packet encodings and width helpers for the link responder.
// Packet structs are declared inside each module from these widths so they track the parameters.
package bsg_manycore_pkg;

    localparam int responder_max_fifo_els_gp = 8;
    localparam int reg_id_width_gp           = 5;
    localparam int op_width_gp               = 2;
    localparam int return_type_width_gp      = 2;

    typedef enum logic [op_width_gp-1:0] {
        e_remote_load  = 2'd0,
        e_remote_store = 2'd1,
        e_remote_amo   = 2'd2,
        e_remote_sw    = 2'd3
    } bsg_manycore_packet_op_e;

    typedef enum logic [return_type_width_gp-1:0] {
        e_return_credit   = 2'd0,
        e_return_int_wb   = 2'd1,
        e_return_float_wb = 2'd2,
        e_return_ifetch   = 2'd3
    } bsg_manycore_return_packet_type_e;

    // Field order of packet_s: addr, op, reg_id, payload, src_y, src_x, y_cord, x_cord.
    function automatic int packet_width(input int a, input int d, input int x, input int y);
        return a + op_width_gp + reg_id_width_gp + d + 2 * (x + y);
    endfunction

    // Field order of return_packet_s: pkt_type, data, reg_id, y_cord, x_cord.
    function automatic int return_packet_width(input int d, input int x, input int y);
        return return_type_width_gp + d + reg_id_width_gp + x + y;
    endfunction

    // link_sif_s = {fwd {v, packet, ready_and_rev}, rev {v, return_packet, ready_and_rev}}.
    function automatic int link_sif_width(input int a, input int d, input int x, input int y);
        return 4 + packet_width(a, d, x, y) + return_packet_width(d, x, y);
    endfunction

endpackage

// File: rtl/bsg_manycore_link_sif_responder.sv
// One terminated manycore link: answers every request, discards stray responses, counts both.
// BSG_MANYCORE_RESPONDER_CAPTURE_EN adds first-offender capture registers.
module bsg_manycore_link_sif_responder
    import bsg_manycore_pkg::*;
#(
    parameter int          addr_width_p   = 28,
    parameter int          data_width_p   = 32,
    parameter int          x_cord_width_p = 4,
    parameter int          y_cord_width_p = 4,
    parameter int          fifo_els_p     = 2,
    parameter int          count_width_p  = 16,
    parameter logic [31:0] error_data_p   = 32'hDEADBEEF,
    localparam int         link_sif_w     = link_sif_width(addr_width_p, data_width_p,
                                                           x_cord_width_p, y_cord_width_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [link_sif_w-1:0]     link_sif_i,
    output logic [link_sif_w-1:0]     link_sif_o,
    input  logic                      clear_i,
    output logic [count_width_p-1:0]  stray_req_cnt_o,
    output logic [count_width_p-1:0]  stray_rsp_cnt_o,
    output logic                      err_o,
    output logic [x_cord_width_p-1:0] first_src_x_o,
    output logic [y_cord_width_p-1:0] first_src_y_o,
    output logic [addr_width_p-1:0]   first_addr_o
);

    typedef struct packed {
        logic [addr_width_p-1:0]     addr;
        bsg_manycore_packet_op_e     op;
        logic [reg_id_width_gp-1:0]  reg_id;
        logic [data_width_p-1:0]     payload;
        logic [y_cord_width_p-1:0]   src_y_cord;
        logic [x_cord_width_p-1:0]   src_x_cord;
        logic [y_cord_width_p-1:0]   y_cord;
        logic [x_cord_width_p-1:0]   x_cord;
    } packet_s;

    typedef struct packed {
        bsg_manycore_return_packet_type_e pkt_type;
        logic [data_width_p-1:0]          data;
        logic [reg_id_width_gp-1:0]       reg_id;
        logic [y_cord_width_p-1:0]        y_cord;
        logic [x_cord_width_p-1:0]        x_cord;
    } return_packet_s;

    typedef struct packed {
        logic    v;
        packet_s data;
        logic    ready_and_rev;
    } fwd_s;

    typedef struct packed {
        logic           v;
        return_packet_s data;
        logic           ready_and_rev;
    } rev_s;

    typedef struct packed {
        fwd_s fwd;
        rev_s rev;
    } link_sif_s;

    localparam int ptr_w   = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int mem_els = 1 << ptr_w;
    localparam logic [data_width_p-1:0] err_data_lp = data_width_p'(error_data_p);

    link_sif_s link_in, link_out;
    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    return_packet_s   mem_q [mem_els];
    return_packet_s   rsp;
    logic             full, empty, fwd_ready, req_acc, rsp_acc, pop;

    // Ready looks only at the registered occupancy, never at the same-cycle pop.
    assign full      = (count_q == 4'(fifo_els_p));
    assign empty     = (count_q == 4'd0);
    assign fwd_ready = reset_n_i & ~full;
    assign req_acc   = link_in.fwd.v & fwd_ready;
    assign rsp_acc   = link_in.rev.v;
    assign pop       = ~empty & link_in.rev.ready_and_rev;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [count_width_p-1:0] sat_next(input logic [count_width_p-1:0] cnt,
                                                          input logic ev, input logic clr);
        if (clr)                  return ev ? count_width_p'(1) : '0;
        else if (ev && ~&cnt)     return cnt + count_width_p'(1);
        else                      return cnt;
    endfunction

    always_comb begin
        rsp            = '0;
        rsp.reg_id     = link_in.fwd.data.reg_id;
        rsp.x_cord     = link_in.fwd.data.src_x_cord;
        rsp.y_cord     = link_in.fwd.data.src_y_cord;
        rsp.pkt_type   = e_return_credit;
        if (link_in.fwd.data.op == e_remote_load) begin
            rsp.pkt_type = e_return_int_wb;
            rsp.data     = err_data_lp;
        end
    end

    always_comb begin
        wr_ptr_d = req_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + {3'b000, req_acc} - {3'b000, pop};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by count_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (req_acc) mem_q[wr_ptr_q] <= rsp;
    end

    always_comb begin
        link_out                   = '0;
        link_out.fwd.ready_and_rev = fwd_ready;
        link_out.rev.v             = ~empty;
        link_out.rev.data          = mem_q[rd_ptr_q];
        link_out.rev.ready_and_rev = 1'b1;
    end

    logic [count_width_p-1:0] req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
    logic                     err_q, err_d;

    always_comb begin
        req_cnt_d = sat_next(req_cnt_q, req_acc, clear_i);
        rsp_cnt_d = sat_next(rsp_cnt_q, rsp_acc, clear_i);
        err_d     = (req_acc | rsp_acc) ? 1'b1 : (clear_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
        end
    end

    assign stray_req_cnt_o = req_cnt_q;
    assign stray_rsp_cnt_o = rsp_cnt_q;
    assign err_o           = err_q;

`ifdef BSG_MANYCORE_RESPONDER_CAPTURE_EN
    logic                      captured_q, captured_d;
    logic [x_cord_width_p-1:0] first_x_q, first_x_d;
    logic [y_cord_width_p-1:0] first_y_q, first_y_d;
    logic [addr_width_p-1:0]   first_addr_q, first_addr_d;

    // A request coinciding with clear starts a fresh capture window.
    always_comb begin
        captured_d   = captured_q;
        first_x_d    = first_x_q;
        first_y_d    = first_y_q;
        first_addr_d = first_addr_q;
        if (req_acc && (clear_i || !captured_q)) begin
            captured_d   = 1'b1;
            first_x_d    = link_in.fwd.data.src_x_cord;
            first_y_d    = link_in.fwd.data.src_y_cord;
            first_addr_d = link_in.fwd.data.addr;
        end else if (clear_i) begin
            captured_d   = 1'b0;
            first_x_d    = '0;
            first_y_d    = '0;
            first_addr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            captured_q   <= 1'b0;
            first_x_q    <= '0;
            first_y_q    <= '0;
            first_addr_q <= '0;
        end else begin
            captured_q   <= captured_d;
            first_x_q    <= first_x_d;
            first_y_q    <= first_y_d;
            first_addr_q <= first_addr_d;
        end
    end

    assign first_src_x_o = first_x_q;
    assign first_src_y_o = first_y_q;
    assign first_addr_o  = first_addr_q;

    logic unused_bits;
    assign unused_bits = ^{link_in.fwd.ready_and_rev, link_in.fwd.data.payload,
                           link_in.fwd.data.x_cord, link_in.fwd.data.y_cord, link_in.rev.data};
`else
    assign first_src_x_o = '0;
    assign first_src_y_o = '0;
    assign first_addr_o  = '0;

    logic unused_bits;
    assign unused_bits = ^{link_in.fwd.ready_and_rev, link_in.fwd.data.payload,
                           link_in.fwd.data.addr, link_in.fwd.data.x_cord,
                           link_in.fwd.data.y_cord, link_in.rev.data};
`endif

endmodule

// File: rtl/bsg_manycore_link_sif_responder_array.sv
// Active terminator for num_links_p unused manycore edge links; one responder per link.
// BSG_MANYCORE_RESPONDER_CAPTURE_EN enables first-offender capture on every link.
module bsg_manycore_link_sif_responder_array
    import bsg_manycore_pkg::*;
#(
    parameter int          addr_width_p   = 28,
    parameter int          data_width_p   = 32,
    parameter int          x_cord_width_p = 4,
    parameter int          y_cord_width_p = 4,
    parameter int          num_links_p    = 1,
    parameter int          fifo_els_p     = 2,
    parameter int          count_width_p  = 16,
    parameter logic [31:0] error_data_p   = 32'hDEADBEEF,
    localparam int         link_sif_w     = link_sif_width(addr_width_p, data_width_p,
                                                           x_cord_width_p, y_cord_width_p)
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [num_links_p-1:0][link_sif_w-1:0]     link_sif_i,
    output logic [num_links_p-1:0][link_sif_w-1:0]     link_sif_o,
    input  logic                                       clear_i,
    output logic [num_links_p-1:0][count_width_p-1:0]  stray_req_cnt_o,
    output logic [num_links_p-1:0][count_width_p-1:0]  stray_rsp_cnt_o,
    output logic [num_links_p-1:0]                     err_o,
    output logic [num_links_p-1:0][x_cord_width_p-1:0] first_src_x_o,
    output logic [num_links_p-1:0][y_cord_width_p-1:0] first_src_y_o,
    output logic [num_links_p-1:0][addr_width_p-1:0]   first_addr_o
);

    for (genvar i = 0; i < num_links_p; i++) begin : g_link
        bsg_manycore_link_sif_responder #(
            .addr_width_p   (addr_width_p),
            .data_width_p   (data_width_p),
            .x_cord_width_p (x_cord_width_p),
            .y_cord_width_p (y_cord_width_p),
            .fifo_els_p     (fifo_els_p),
            .count_width_p  (count_width_p),
            .error_data_p   (error_data_p)
        ) u_responder (
            .clk_i           (clk_i),
            .reset_n_i       (reset_n_i),
            .link_sif_i      (link_sif_i[i]),
            .link_sif_o      (link_sif_o[i]),
            .clear_i         (clear_i),
            .stray_req_cnt_o (stray_req_cnt_o[i]),
            .stray_rsp_cnt_o (stray_rsp_cnt_o[i]),
            .err_o           (err_o[i]),
            .first_src_x_o   (first_src_x_o[i]),
            .first_src_y_o   (first_src_y_o[i]),
            .first_addr_o    (first_addr_o[i])
        );
    end

endmodule

// File: tb/tb_bsg_manycore_link_sif_responder_array.sv
// Directed bench for the link responder array: three links, two-deep FIFOs, 4-bit counters.
module tb_bsg_manycore_link_sif_responder_array;
    import bsg_manycore_pkg::*;

    localparam int A = 8, D = 32, X = 3, Y = 2, NL = 3, FE = 2, CW = 4;
    localparam int LW = link_sif_width(A, D, X, Y);

    typedef struct packed {
        logic [A-1:0] addr; bsg_manycore_packet_op_e op; logic [4:0] reg_id; logic [D-1:0] payload;
        logic [Y-1:0] src_y_cord; logic [X-1:0] src_x_cord; logic [Y-1:0] y_cord; logic [X-1:0] x_cord;
    } packet_s;
    typedef struct packed {
        bsg_manycore_return_packet_type_e pkt_type; logic [D-1:0] data; logic [4:0] reg_id;
        logic [Y-1:0] y_cord; logic [X-1:0] x_cord;
    } return_packet_s;
    typedef struct packed { logic v; packet_s data; logic ready_and_rev; } fwd_s;
    typedef struct packed { logic v; return_packet_s data; logic ready_and_rev; } rev_s;
    typedef struct packed { fwd_s fwd; rev_s rev; } link_sif_s;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    logic [NL-1:0][LW-1:0] link_sif_i, link_sif_o;
    logic [NL-1:0][CW-1:0] req_cnt, rsp_cnt;
    logic [NL-1:0]         err;
    logic [NL-1:0][X-1:0]  first_x;
    logic [NL-1:0][Y-1:0]  first_y;
    logic [NL-1:0][A-1:0]  first_addr;
    link_sif_s in_s [NL];
    link_sif_s out_s [NL];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            link_sif_i[i] = in_s[i];
            out_s[i]      = link_sif_o[i];
        end
    end

    bsg_manycore_link_sif_responder_array #(
        .addr_width_p(A), .data_width_p(D), .x_cord_width_p(X), .y_cord_width_p(Y),
        .num_links_p(NL), .fifo_els_p(FE), .count_width_p(CW), .error_data_p(32'hDEADBEEF)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .link_sif_i(link_sif_i), .link_sif_o(link_sif_o),
        .clear_i(clear), .stray_req_cnt_o(req_cnt), .stray_rsp_cnt_o(rsp_cnt), .err_o(err),
        .first_src_x_o(first_x), .first_src_y_o(first_y), .first_addr_o(first_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NL; i++) begin
            in_s[i] = '0;
            in_s[i].rev.ready_and_rev = 1'b1;
        end
        clear = 1'b0;
    endtask

    task automatic set_req(input int l, input bsg_manycore_packet_op_e op, input logic [X-1:0] sx,
                           input logic [Y-1:0] sy, input logic [A-1:0] addr, input logic [4:0] rid);
        in_s[l].fwd.v                 = 1'b1;
        in_s[l].fwd.data.op           = op;
        in_s[l].fwd.data.src_x_cord   = sx;
        in_s[l].fwd.data.src_y_cord   = sy;
        in_s[l].fwd.data.addr         = addr;
        in_s[l].fwd.data.reg_id       = rid;
        in_s[l].fwd.data.payload      = 32'h1234_5678;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (out_s[i].fwd.ready_and_rev !== 1'b0) begin
                errors++; $display("FAIL reset_fwd_ready[%0d]: got %0b expected 0", i, out_s[i].fwd.ready_and_rev);
            end
            checks++;
            if (out_s[i].rev.v !== 1'b0) begin
                errors++; $display("FAIL reset_rev_v[%0d]: got %0b expected 0", i, out_s[i].rev.v);
            end
        end
        #3 reset_n = 1'b1;
        #1;
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (out_s[i].fwd.ready_and_rev !== 1'b1) begin
                errors++; $display("FAIL post_reset_ready[%0d]: got %0b expected 1", i, out_s[i].fwd.ready_and_rev);
            end
            checks++;
            if (req_cnt[i] !== '0 || rsp_cnt[i] !== '0 || err[i] !== 1'b0 || first_addr[i] !== '0) begin
                errors++; $display("FAIL post_reset_state[%0d]: got req=%0d rsp=%0d err=%0b addr=%0h expected all 0",
                                   i, req_cnt[i], rsp_cnt[i], err[i], first_addr[i]);
            end
        end
    endtask

    task automatic test_load();
        set_req(0, e_remote_load, 3'd2, 2'd3, 8'h40, 5'd9);
        tick();
        in_s[0].fwd.v = 1'b0;
        checks++;
        if (out_s[0].rev.v !== 1'b1) begin
            errors++; $display("FAIL load_rev_v: got %0b expected 1", out_s[0].rev.v);
        end
        checks++;
        if (out_s[0].rev.data.pkt_type !== e_return_int_wb || out_s[0].rev.data.data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_rsp: got type=%0d data=%0h expected type=1 data=deadbeef",
                               out_s[0].rev.data.pkt_type, out_s[0].rev.data.data);
        end
        checks++;
        if (out_s[0].rev.data.x_cord !== 3'd2 || out_s[0].rev.data.y_cord !== 2'd3 || out_s[0].rev.data.reg_id !== 5'd9) begin
            errors++; $display("FAIL load_dst: got x=%0d y=%0d reg=%0d expected x=2 y=3 reg=9",
                               out_s[0].rev.data.x_cord, out_s[0].rev.data.y_cord, out_s[0].rev.data.reg_id);
        end
        checks++;
        if (req_cnt[0] !== 4'd1 || err[0] !== 1'b1 || req_cnt[1] !== 4'd0 || req_cnt[2] !== 4'd0) begin
            errors++; $display("FAIL load_counts: got cnt0=%0d err0=%0b cnt1=%0d cnt2=%0d expected 1 1 0 0",
                               req_cnt[0], err[0], req_cnt[1], req_cnt[2]);
        end
        tick();
        checks++;
        if (out_s[0].rev.v !== 1'b0) begin
            errors++; $display("FAIL load_drain: got rev.v=%0b expected 0", out_s[0].rev.v);
        end
    endtask

    task automatic test_store();
        set_req(1, e_remote_store, 3'd5, 2'd1, 8'h10, 5'd7);
        tick();
        in_s[1].fwd.v = 1'b0;
        checks++;
        if (out_s[1].rev.v !== 1'b1 || out_s[1].rev.data.pkt_type !== e_return_credit || out_s[1].rev.data.data !== '0) begin
            errors++; $display("FAIL store_rsp: got v=%0b type=%0d data=%0h expected v=1 type=0 data=0",
                               out_s[1].rev.v, out_s[1].rev.data.pkt_type, out_s[1].rev.data.data);
        end
        checks++;
        if (out_s[1].rev.data.x_cord !== 3'd5 || out_s[1].rev.data.y_cord !== 2'd1 || out_s[1].rev.data.reg_id !== 5'd7) begin
            errors++; $display("FAIL store_dst: got x=%0d y=%0d reg=%0d expected 5 1 7",
                               out_s[1].rev.data.x_cord, out_s[1].rev.data.y_cord, out_s[1].rev.data.reg_id);
        end
        checks++;
        if (req_cnt[1] !== 4'd1 || req_cnt[0] !== 4'd1 || req_cnt[2] !== 4'd0 || err[2] !== 1'b0) begin
            errors++; $display("FAIL store_counts: got cnt1=%0d cnt0=%0d cnt2=%0d err2=%0b expected 1 1 0 0",
                               req_cnt[1], req_cnt[0], req_cnt[2], err[2]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        in_s[2].rev.ready_and_rev = 1'b0;
        set_req(2, e_remote_load, 3'd1, 2'd1, 8'h01, 5'd1);
        tick();
        set_req(2, e_remote_load, 3'd1, 2'd1, 8'h02, 5'd2);
        tick();
        checks++;
        if (out_s[2].fwd.ready_and_rev !== 1'b0 || req_cnt[2] !== 4'd2) begin
            errors++; $display("FAIL b2b_full: got ready=%0b cnt=%0d expected 0 2", out_s[2].fwd.ready_and_rev, req_cnt[2]);
        end
        set_req(2, e_remote_load, 3'd1, 2'd1, 8'h03, 5'd3);
        tick();
        checks++;
        if (req_cnt[2] !== 4'd2 || out_s[2].rev.v !== 1'b1 || out_s[2].rev.data.reg_id !== 5'd1) begin
            errors++; $display("FAIL b2b_stall: got cnt=%0d v=%0b reg=%0d expected 2 1 1",
                               req_cnt[2], out_s[2].rev.v, out_s[2].rev.data.reg_id);
        end
        checks++;
        if (out_s[0].fwd.ready_and_rev !== 1'b1 || out_s[1].fwd.ready_and_rev !== 1'b1) begin
            errors++; $display("FAIL b2b_isolation: got ready0=%0b ready1=%0b expected 1 1",
                               out_s[0].fwd.ready_and_rev, out_s[1].fwd.ready_and_rev);
        end
        in_s[2].rev.ready_and_rev = 1'b1;
        tick();
        checks++;
        if (out_s[2].rev.data.reg_id !== 5'd2 || req_cnt[2] !== 4'd2 || out_s[2].fwd.ready_and_rev !== 1'b1) begin
            errors++; $display("FAIL b2b_pop1: got reg=%0d cnt=%0d ready=%0b expected 2 2 1",
                               out_s[2].rev.data.reg_id, req_cnt[2], out_s[2].fwd.ready_and_rev);
        end
        tick();
        in_s[2].fwd.v = 1'b0;
        checks++;
        if (out_s[2].rev.v !== 1'b1 || out_s[2].rev.data.reg_id !== 5'd3 || req_cnt[2] !== 4'd3) begin
            errors++; $display("FAIL b2b_third: got v=%0b reg=%0d cnt=%0d expected 1 3 3",
                               out_s[2].rev.v, out_s[2].rev.data.reg_id, req_cnt[2]);
        end
        tick();
        checks++;
        if (out_s[2].rev.v !== 1'b0) begin
            errors++; $display("FAIL b2b_empty: got v=%0b expected 0", out_s[2].rev.v);
        end
    endtask

    task automatic test_stray_rsp();
        in_s[1].rev.v = 1'b1;
        in_s[1].rev.data.data = 32'hCAFE_0001;
        #1;
        checks++;
        if (out_s[1].rev.ready_and_rev !== 1'b1) begin
            errors++; $display("FAIL rsp_ready: got %0b expected 1", out_s[1].rev.ready_and_rev);
        end
        repeat (3) tick();
        in_s[1].rev.v = 1'b0;
        checks++;
        if (rsp_cnt[1] !== 4'd3 || req_cnt[1] !== 4'd1 || rsp_cnt[0] !== 4'd0) begin
            errors++; $display("FAIL rsp_counts: got rsp1=%0d req1=%0d rsp0=%0d expected 3 1 0",
                               rsp_cnt[1], req_cnt[1], rsp_cnt[0]);
        end
    endtask

    task automatic test_saturate();
        logic [X-1:0] ex_x;
        logic [Y-1:0] ex_y;
        logic [A-1:0] ex_a;
        set_req(0, e_remote_store, 3'd4, 2'd2, 8'h55, 5'd0);
        repeat (20) tick();
        in_s[0].fwd.v = 1'b0;
        checks++;
        if (req_cnt[0] !== 4'd15) begin
            errors++; $display("FAIL sat_value: got %0d expected 15", req_cnt[0]);
        end
        tick();
        checks++;
        if (req_cnt[0] !== 4'd15) begin
            errors++; $display("FAIL sat_hold: got %0d expected 15", req_cnt[0]);
        end
        clear = 1'b1;
        set_req(0, e_remote_load, 3'd6, 2'd1, 8'h66, 5'd4);
        tick();
        clear = 1'b0;
        in_s[0].fwd.v = 1'b0;
        checks++;
        if (req_cnt[0] !== 4'd1 || err[0] !== 1'b1) begin
            errors++; $display("FAIL clear_with_event: got cnt=%0d err=%0b expected 1 1", req_cnt[0], err[0]);
        end
        checks++;
        if (req_cnt[1] !== 4'd0 || rsp_cnt[1] !== 4'd0 || err[1] !== 1'b0 || req_cnt[2] !== 4'd0 || err[2] !== 1'b0) begin
            errors++; $display("FAIL clear_others: got req1=%0d rsp1=%0d err1=%0b req2=%0d err2=%0b expected all 0",
                               req_cnt[1], rsp_cnt[1], err[1], req_cnt[2], err[2]);
        end
`ifdef BSG_MANYCORE_RESPONDER_CAPTURE_EN
        ex_x = 3'd6; ex_y = 2'd1; ex_a = 8'h66;
`else
        ex_x = '0; ex_y = '0; ex_a = '0;
`endif
        checks++;
        if (first_x[0] !== ex_x || first_y[0] !== ex_y || first_addr[0] !== ex_a) begin
            errors++; $display("FAIL clear_capture0: got (%0d,%0d,%0h) expected (%0d,%0d,%0h)",
                               first_x[0], first_y[0], first_addr[0], ex_x, ex_y, ex_a);
        end
        tick();
    endtask

    task automatic test_capture();
        logic [X-1:0] ex_x;
        logic [Y-1:0] ex_y;
        logic [A-1:0] ex_a;
        set_req(1, e_remote_store, 3'd1, 2'd0, 8'h11, 5'd0);
        tick();
        set_req(1, e_remote_store, 3'd3, 2'd2, 8'h22, 5'd0);
        tick();
        in_s[1].fwd.v = 1'b0;
`ifdef BSG_MANYCORE_RESPONDER_CAPTURE_EN
        ex_x = 3'd1; ex_y = 2'd0; ex_a = 8'h11;
`else
        ex_x = '0; ex_y = '0; ex_a = '0;
`endif
        checks++;
        if (first_x[1] !== ex_x || first_y[1] !== ex_y || first_addr[1] !== ex_a) begin
            errors++; $display("FAIL capture_first: got (%0d,%0d,%0h) expected (%0d,%0d,%0h)",
                               first_x[1], first_y[1], first_addr[1], ex_x, ex_y, ex_a);
        end
        checks++;
        if (first_x[2] !== '0 || first_y[2] !== '0 || first_addr[2] !== '0) begin
            errors++; $display("FAIL capture_idle_link: got (%0d,%0d,%0h) expected (0,0,0)",
                               first_x[2], first_y[2], first_addr[2]);
        end
        clear = 1'b1;
        set_req(1, e_remote_store, 3'd3, 2'd2, 8'h33, 5'd0);
        tick();
        clear = 1'b0;
        in_s[1].fwd.v = 1'b0;
`ifdef BSG_MANYCORE_RESPONDER_CAPTURE_EN
        ex_x = 3'd3; ex_y = 2'd2; ex_a = 8'h33;
`endif
        checks++;
        if (first_x[1] !== ex_x || first_y[1] !== ex_y || first_addr[1] !== ex_a) begin
            errors++; $display("FAIL capture_on_clear: got (%0d,%0d,%0h) expected (%0d,%0d,%0h)",
                               first_x[1], first_y[1], first_addr[1], ex_x, ex_y, ex_a);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        in_s[2].rev.ready_and_rev = 1'b0;
        set_req(2, e_remote_load, 3'd0, 2'd1, 8'h70, 5'd1);
        tick();
        set_req(2, e_remote_load, 3'd0, 2'd1, 8'h71, 5'd2);
        tick();
        in_s[2].fwd.v = 1'b0;
        checks++;
        if (out_s[2].rev.v !== 1'b1 || out_s[2].fwd.ready_and_rev !== 1'b0) begin
            errors++; $display("FAIL mid_queued: got v=%0b ready=%0b expected 1 0", out_s[2].rev.v, out_s[2].fwd.ready_and_rev);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_s[2].rev.v !== 1'b0 || out_s[2].fwd.ready_and_rev !== 1'b0) begin
            errors++; $display("FAIL mid_async_drop: got v=%0b ready=%0b expected 0 0", out_s[2].rev.v, out_s[2].fwd.ready_and_rev);
        end
        @(negedge clk);
        reset_n = 1'b1;
        in_s[2].rev.ready_and_rev = 1'b1;
        #1;
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (req_cnt[i] !== '0 || rsp_cnt[i] !== '0 || err[i] !== 1'b0 ||
                out_s[i].fwd.ready_and_rev !== 1'b1 || out_s[i].rev.v !== 1'b0) begin
                errors++; $display("FAIL mid_release[%0d]: got req=%0d rsp=%0d err=%0b ready=%0b v=%0b expected 0 0 0 1 0",
                                   i, req_cnt[i], rsp_cnt[i], err[i], out_s[i].fwd.ready_and_rev, out_s[i].rev.v);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_stray_rsp();
        test_saturate();
        test_capture();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
